// File: rtl/dff8_share_arbiter_pkg.sv
// rtl/dff8_share_arbiter_pkg.sv - shared types and width helpers for the shared-register arbiter
package dff8_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Requester index width; a 2-requester arbiter still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Hold counter width: it only ever holds HOLD_CYCLES-1 down to 0.
  function automatic int cnt_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/dff8_share_arbiter_rr_pick.sv
// rtl/dff8_share_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk from the farthest candidate back to ptr so the nearest set bit wins.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/dff8_share_arbiter.sv
// rtl/dff8_share_arbiter.sv - round-robin write sequencer in front of the shared clearable register
module dff8_share_arbiter
  import dff8_share_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      CLK,
  input  logic                      Asynch_clr,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH-1:0]    wr_data,
  input  logic                      clr_req,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic                      clr_ack,
  output logic [WIDTH-1:0]          Q,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic                      busy
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CW    = cnt_w(HOLD_CYCLES);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   owner_n;
  logic [N_REQ-1:0]   gnt_n, ack_n;
  logic               clr_ack_n;
  logic [WIDTH-1:0]   q_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State register.
  always_ff @(posedge CLK or posedge Asynch_clr) begin
    if (Asynch_clr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    gnt_n     = gnt;
    ack_n     = '0;
    clr_ack_n = 1'b0;
    q_n       = Q;
    cnt_n     = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
        end else if (pick_valid) begin
          gnt_n   = N_REQ'(1) << pick_idx;
          owner_n = pick_idx;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (req[owner]) begin
          q_n     = wr_data[int'(owner)*WIDTH +: WIDTH];
          ack_n   = N_REQ'(1) << owner;
          cnt_n   = CW'(HOLD_CYCLES - 1);
          state_n = HOLD;
        end else begin
          // Requester withdrew: release without writing and keep ptr so it is not skipped.
          gnt_n   = '0;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          gnt_n   = '0;
          ptr_n   = (int'(owner) == N_REQ - 1) ? '0 : owner + IDX_W'(1);
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      CLEAR: begin
        q_n       = '0;
        clr_ack_n = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK or posedge Asynch_clr) begin
    if (Asynch_clr) begin
      ptr     <= '0;
      owner   <= '0;
      gnt     <= '0;
      ack     <= '0;
      clr_ack <= 1'b0;
      cnt     <= '0;
    end else begin
      ptr     <= ptr_n;
      owner   <= owner_n;
      gnt     <= gnt_n;
      ack     <= ack_n;
      clr_ack <= clr_ack_n;
      cnt     <= cnt_n;
    end
  end

  // The shared datapath register, cleared asynchronously like the original D-register.
  always_ff @(posedge CLK or posedge Asynch_clr) begin
    if (Asynch_clr) begin
      Q <= '0;
    end else begin
      Q <= q_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff8_share_arbiter.sv
// tb/tb_dff8_share_arbiter.sv - scoreboard bench for the shared-register arbiter
module tb_dff8_share_arbiter;

  logic        CLK;
  logic        Asynch_clr;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic        clr_req;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        clr_ack;
  logic [7:0]  Q;
  logic [1:0]  owner;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_clr;
    logic [3:0] ack;
    logic [7:0] q;
    logic [1:0] owner;
  } exp_t;

  exp_t sb[$];

  dff8_share_arbiter dut (
    .CLK        (CLK),
    .Asynch_clr (Asynch_clr),
    .req        (req),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .gnt        (gnt),
    .ack        (ack),
    .clr_ack    (clr_ack),
    .Q          (Q),
    .owner      (owner),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push_wr(input int idx, input logic [7:0] d);
    exp_t e;
    e.is_clr = 1'b0;
    e.ack    = 4'b0001 << idx;
    e.q      = d;
    e.owner  = 2'(idx);
    sb.push_back(e);
  endtask

  task automatic push_clr();
    exp_t e;
    e.is_clr = 1'b1;
    e.ack    = 4'b0000;
    e.q      = 8'h00;
    e.owner  = 2'd0;
    sb.push_back(e);
  endtask

  task automatic set_data(input int idx, input logic [7:0] d);
    wr_data[idx*8 +: 8] = d;
  endtask

  task automatic wait_ack(input int idx);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (ack[idx]) seen = 1;
    end
    chk($sformatf("ack%0d_timeout", idx), 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (!busy) seen = 1;
    end
    chk("idle_timeout", 32'(seen), 32'd1);
  endtask

  // Monitor: every ack or clr_ack pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!Asynch_clr) begin
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (ack != 4'b0000 || clr_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {27'd0, clr_ack, ack}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_clr_ack", 32'(clr_ack), 32'(e.is_clr));
          chk("sb_ack", 32'(ack), 32'(e.ack));
          chk("sb_q", 32'(Q), 32'(e.q));
          if (!e.is_clr) chk("sb_owner", 32'(owner), 32'(e.owner));
        end
      end
    end
  end

  initial begin
    Asynch_clr = 1'b1;
    req        = '0;
    wr_data    = '0;
    clr_req    = 1'b0;
    tick();
    tick();
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_clr_ack", 32'(clr_ack), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Asynch_clr = 1'b0;
    tick();

    // Single write: gnt after 1 edge, ack/Q after 2, release after 2+HOLD_CYCLES.
    set_data(0, 8'hA5);
    req = 4'b0001;
    push_wr(0, 8'hA5);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_gnt_hold", 32'(gnt), 32'h1);
    chk("t1_ack_pulse", 32'(ack), 32'h0);
    tick();
    chk("t1_gnt_rel", 32'(gnt), 32'h0);
    chk("t1_busy_rel", 32'(busy), 32'd0);

    // All four requesting for 20 cycles from a fresh pointer: order 0,1,2,3,0.
    Asynch_clr = 1'b1;
    tick();
    Asynch_clr = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    push_wr(0, 8'h10);
    push_wr(1, 8'h11);
    push_wr(2, 8'h12);
    push_wr(3, 8'h13);
    push_wr(0, 8'h10);
    req = 4'b1111;
    for (int i = 0; i < 20; i++) tick();
    req = 4'b0000;
    wait_idle();
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);

    // Load 0xFF through requester 3 so the clear is visible.
    set_data(3, 8'hFF);
    req = 4'b1000;
    push_wr(3, 8'hFF);
    wait_ack(3);
    req = 4'b0000;
    wait_idle();

    // Clear and request together: clear goes first, then requester 2.
    set_data(2, 8'h5A);
    clr_req = 1'b1;
    req     = 4'b0100;
    push_clr();
    push_wr(2, 8'h5A);
    tick();
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_no_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t3_clr_ack", 32'(clr_ack), 32'd1);
    chk("t3_q_clr", 32'(Q), 32'h00);
    clr_req = 1'b0;
    wait_ack(2);
    req = 4'b0000;
    wait_idle();

    // Withdraw during GRANT: no write, no ack, pointer stays at 3.
    set_data(1, 8'h77);
    req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("t4_abort_gnt", 32'(gnt), 32'h0);
    chk("t4_abort_q", 32'(Q), 32'h5A);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_owner", 32'(owner), 32'd1);
    // From ptr 3 requester 1 beats 2; an advanced ptr (2) would pick 2.
    set_data(2, 8'h88);
    req = 4'b0110;
    push_wr(1, 8'h77);
    push_wr(2, 8'h88);
    tick();
    chk("t4_regnt", 32'(gnt), 32'h2);
    wait_ack(1);
    req = 4'b0100;
    wait_ack(2);
    req = 4'b0000;
    wait_idle();

    // Async clear in the middle of HOLD.
    set_data(0, 8'h3C);
    req = 4'b0001;
    push_wr(0, 8'h3C);
    wait_ack(0);
    req = 4'b0000;
    #2;
    Asynch_clr = 1'b1;
    #1;
    chk("t5_q", 32'(Q), 32'h00);
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    tick();
    Asynch_clr = 1'b0;
    set_data(3, 8'hC3);
    req = 4'b1000;
    push_wr(3, 8'hC3);
    tick();
    chk("t5_gnt3", 32'(gnt), 32'h8);
    wait_ack(3);
    req = 4'b0000;
    wait_idle();
    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff8_share_arbiter.md
# dff8_share_arbiter

Round-robin arbiter and write sequencer that shares one 8-bit clearable register among `N_REQ` requesters. It accepts per-requester write requests, grants one owner at a time, loads that owner's data into the register, and holds ownership for a fixed window before re-arbitrating. It sits directly in front of the team's 8-bit D-register datapath and replaces ad-hoc muxing of that register's `D` input.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: register width.
- `HOLD_CYCLES`, default 2: cycles of ownership after the load (≥1).

Ports:
- `CLK`  in  1: single clock; all state updates on posedge.
- `Asynch_clr`  in  1: reset is asynchronous and active-high; it clears all state immediately.
- `req`  in  N_REQ: per-requester write request; level; must be held until `ack` or withdrawn.
- `wr_data`  in  N_REQ*WIDTH: packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- `clr_req`  in  1: synchronous clear request for the shared register; highest priority.
- `gnt`  out  N_REQ: one-hot grant, registered.
- `ack`  out  N_REQ: one-cycle pulse when requester's data has been written.
- `clr_ack`  out  1: one-cycle pulse when the synchronous clear has been applied.
- `Q`  out  WIDTH: shared register contents.
- `owner`  out  clog2(N_REQ): index of current or last owner.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Reset values: `Q`=0, `gnt`=0, `ack`=0, `clr_ack`=0, `owner`=0, `busy`=0, FSM=IDLE, round-robin pointer `ptr`=0.
- States: IDLE, GRANT, HOLD, CLEAR.
- IDLE:
  - If `clr_req` is high, go to CLEAR.
  - Otherwise, if any `req` bit is high, pick the first set bit searching from `ptr` upward with wrap. Set `gnt`=onehot(i) and `owner`=i, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - If `req[owner]` is still high, load `Q` with the owner's `wr_data` slice, pulse `ack[owner]`, load the hold counter with HOLD_CYCLES-1, and go to HOLD.
  - If `req[owner]` has dropped, abort: no write, no ack, `gnt`=0, `ptr` unchanged, go to IDLE.
- HOLD:
  - `gnt` stays asserted and `Q` is stable. The counter decrements each cycle.
  - When the counter reaches 0: `gnt`=0, `ptr`=owner+1 mod N_REQ, go to IDLE.
- CLEAR (1 cycle): `Q`=0, pulse `clr_ack`, go to IDLE. `ptr` and `owner` are unchanged.
- `clr_req` is sampled only in IDLE. It never preempts GRANT or HOLD. It stays pending until `clr_ack`.
- `wr_data` is sampled only on the GRANT→HOLD edge.
- Simultaneous `clr_req` and `req` in IDLE: the clear wins. The requesters are arbitrated on the next IDLE cycle.
- A requester still holding `req` after its own `ack` re-competes, with lowest priority because `ptr` has advanced past it.
- Asserting `Asynch_clr` mid-operation returns all state to reset values immediately. Any pending request is lost without an ack.

## Timing
- `req` sampled high in IDLE at edge k:
  - `gnt` high after edge k.
  - `Q` updated and `ack` high after edge k+1.
  - `gnt` low after edge k+1+HOLD_CYCLES.
- Back-to-back grants: a new grant is issued no earlier than 1 IDLE cycle after release. The minimum period per write is HOLD_CYCLES+2 cycles.
- `clr_req` sampled in IDLE at edge k: `Q`=0 and `clr_ack` high after edge k+1.
- All outputs are registered. There are no combinational input→output paths.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE=0, GRANT=1, HOLD=2, CLEAR=3);
  - the `IDX_W` = clog2(N_REQ) helper;
  - the counter width derived from HOLD_CYCLES.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs `req` and `ptr`; outputs `valid` and index. It is reusable by later arbiters.
- `Q` is the only datapath register. It has the same async-clear semantics as the team's 8-bit register.

## Test plan
- Reset, then `req`=0001 with data0=0xA5 → `gnt`=0001 after 1 cycle; `Q`=0xA5 and `ack`=0001 after 2 cycles; `gnt` clear after 2+HOLD_CYCLES.
- `req`=1111 held for 20 cycles, data i = 0x10+i → grant order 0,1,2,3,0; each `Q` value matches its owner; no two `gnt` bits set in the same cycle.
- `clr_req` and `req`=0100 together in IDLE with `Q`=0xFF → CLEAR first: `Q`=0x00 and `clr_ack` pulse; then requester 2 is granted and `Q`=its data.
- `req`=0010 dropped during GRANT → no `ack`, `Q` unchanged, `ptr` unchanged; re-raise → requester 1 is granted again.
- `Asynch_clr` pulsed mid-HOLD with `Q`=0x3C → `Q`=0, `gnt`=0, `busy`=0 immediately; after release, `req`=1000 is granted as if from fresh reset.
